keypad_scanner: RTL and testbench

Matrix keypad reader for the board I/O path; it is the input-side counterpart of the display digit scanner. It drives a 4x4 key matrix one column at a time, samples the rows, debounces a single pressed key and delivers a 4-bit key code over a valid/ready handshake to the CPU's memory-mapped input port. Timing is on the single system clock; no derived clocks.

---
 rtl/keypad_scanner.sv | 202 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad reader. Drives one column at a time, samples
// the synchronized rows once per dwell period, debounces a single closed key and
// hands its code to the consumer over a valid/ready handshake.
// Optional feature: define KEY_REPEAT_EN to re-emit a held key after REPEAT_DELAY
// sample points and then every REPEAT_RATE sample points.
//
// state    | meaning
// SCAN     | rotating columns, looking for exactly one closed row
// DEBOUNCE | column frozen, counting samples that match the captured row
// HELD     | key accepted; waiting for an all-open sample (repeating if enabled)
// RELEASE  | counting all-open samples before the scan resumes
module keypad_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overrun
);

  typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2, RELEASE = 2'd3} state_t;

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);
  // With a single required sample the key is accepted (and released) on the first hit.
  localparam bit ACCEPT_ON_FIRST = (DEBOUNCE_CNT == 1);

  // Reject parameter sets the scan timing cannot support.
  if (SCAN_DIV < 3 || DEBOUNCE_CNT < 1 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_param_check
    $error("keypad_scanner: illegal parameter set");
  end

  state_t        state, state_nx;
  logic [3:0]    row_meta, sample;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [3:0]    cap_row, cap_code;
  logic [CW-1:0] db_cnt;
  logic [1:0]    row_idx;
  logic [3:0]    emit_code;
  logic          sample_pt, one_hot, zero, handshake;
  logic          adv_col, capture, cnt_load, cnt_inc, emit;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);
  logic [RW-1:0] rep_cnt;
  logic          rep_hit;
`endif

  assign sample_pt = (dwell == DWELL_LAST);
  assign one_hot   = $onehot(sample);
  assign zero      = (sample == 4'd0);
  assign handshake = key_valid && key_ready;
  assign col       = 4'b0001 << col_idx;
  // In SCAN with single-sample acceptance the key is emitted in the capture cycle.
  assign emit_code = (state == SCAN) ? {row_idx, col_idx} : cap_code;

  // Encode the single set bit of the sample into a row index.
  always_comb begin
    row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (sample[i]) row_idx = 2'(i);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= SCAN;
    else       state <= state_nx;
  end

  // Next-state decisions, taken only at dwell-end sample points.
  always_comb begin
    state_nx = state;
    if (sample_pt) begin
      case (state)
        SCAN: begin
          if (one_hot) state_nx = ACCEPT_ON_FIRST ? HELD : DEBOUNCE;
        end
        DEBOUNCE: begin
          if (sample != cap_row)       state_nx = SCAN;
          else if (db_cnt == CNT_LAST) state_nx = HELD;
        end
        HELD: begin
          if (zero) state_nx = ACCEPT_ON_FIRST ? SCAN : RELEASE;
        end
        RELEASE: begin
          if (!zero)                   state_nx = HELD;
          else if (db_cnt == CNT_LAST) state_nx = SCAN;
        end
        default: state_nx = SCAN;
      endcase
    end
  end

  // Datapath controls derived from the state and the current sample.
  always_comb begin
    adv_col  = 1'b0;
    capture  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    emit     = 1'b0;
    if (sample_pt) begin
      case (state)
        SCAN: begin
          if (one_hot) begin
            capture  = 1'b1;
            cnt_load = 1'b1;
            emit     = ACCEPT_ON_FIRST;
          end else begin
            adv_col = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (sample == cap_row) begin
            cnt_inc = 1'b1;
            emit    = (db_cnt == CNT_LAST);
          end else begin
            adv_col = 1'b1;
          end
        end
        HELD: begin
          if (zero) begin
            cnt_load = 1'b1;
            adv_col  = ACCEPT_ON_FIRST;
          end
        end
        RELEASE: begin
          if (zero) begin
            cnt_inc = 1'b1;
            adv_col = (db_cnt == CNT_LAST);
          end
        end
        default: ;
      endcase
    end
`ifdef KEY_REPEAT_EN
    if (rep_hit) emit = 1'b1;
`endif
  end

`ifdef KEY_REPEAT_EN
  assign rep_hit = (state == HELD) && sample_pt && !zero && (rep_cnt == REP_LAST);

  // Repeat counter: counts held sample points; after the first repeat it is reloaded
  // so the following hits come every REPEAT_RATE sample points. Idle outside HELD.
  always_ff @(posedge clk) begin
    if (reset || state != HELD) rep_cnt <= '0;
    else if (sample_pt && !zero) rep_cnt <= rep_hit ? REP_RELOAD : rep_cnt + RW'(1);
  end
`endif

  // Synchronizer, dwell timer, column index, debounce count and key output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta  <= '0;
      sample    <= '0;
      dwell     <= '0;
      col_idx   <= '0;
      cap_row   <= '0;
      cap_code  <= '0;
      db_cnt    <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      row_meta <= row;
      sample   <= row_meta;
      dwell    <= sample_pt ? '0 : dwell + DW'(1);
      if (adv_col) col_idx <= col_idx + 2'd1;
      if (capture) begin
        cap_row  <= sample;
        cap_code <= {row_idx, col_idx};
      end
      if (cnt_load)     db_cnt <= CW'(1);
      else if (cnt_inc) db_cnt <= db_cnt + CW'(1);
      // A new key may replace the pending one only when it is being consumed now.
      if (emit) begin
        if (!key_valid || key_ready) begin
          key_code  <= emit_code;
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (handshake) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed scenarios plus randomized key activity, all checked
// every cycle against a sample-point level model of the keypad reader.
module tb_keypad_scanner;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_DELAY = 8;
  localparam int REPEAT_RATE  = 4;
  localparam int P_SCAN = 0, P_DEB = 1, P_HELD = 2, P_REL = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row = '0;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       overrun;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit prev_reset = 1'b0;
  logic [15:0] pressed = '0;
  bit nx_ready = 1'b1;
  bit nx_reset = 1'b1;

  // model state
  bit         m_known = 1'b0;
  logic [3:0] m_h0, m_h1, m_row, m_code, m_kc;
  int         m_dwell, m_col, m_phase, m_cnt, m_rep;
  bit         m_valid, m_ovr;

  // Closed keys connect their row to the driven column.
  function automatic logic [3:0] matrix(input logic [15:0] keys, input logic [3:0] c);
    logic [3:0] res = '0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (keys[r*4+k] && c[k] === 1'b1) res[r] = 1'b1;
    return res;
  endfunction

  function automatic int row_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // One clock edge of the reader, expressed at sample-point granularity.
  task automatic model_step(input logic [3:0] r, input bit rdy, input bit rst);
    logic [3:0] smp;
    bit emit, hs;
    if (rst) begin
      m_known = 1'b1; m_h0 = '0; m_h1 = '0; m_row = '0; m_code = '0; m_kc = '0;
      m_dwell = 0; m_col = 0; m_phase = P_SCAN; m_cnt = 0; m_rep = 0;
      m_valid = 1'b0; m_ovr = 1'b0;
      return;
    end
    smp  = m_h1;
    emit = 1'b0;
    hs   = m_valid && rdy;
    if (m_dwell == SCAN_DIV - 1) begin
      m_dwell = 0;
      case (m_phase)
        P_SCAN: begin
          if ($countones(smp) == 1) begin
            m_row = smp;
            m_code = 4'(row_of(smp) * 4 + m_col);
            m_cnt = 1;
            if (m_cnt >= DEBOUNCE_CNT) begin emit = 1'b1; m_phase = P_HELD; m_rep = 0; end
            else m_phase = P_DEB;
          end else m_col = (m_col + 1) % 4;
        end
        P_DEB: begin
          if (smp == m_row) begin
            m_cnt++;
            if (m_cnt == DEBOUNCE_CNT) begin emit = 1'b1; m_phase = P_HELD; m_rep = 0; end
          end else begin
            m_col = (m_col + 1) % 4;
            m_phase = P_SCAN;
          end
        end
        P_HELD: begin
          if (smp == 4'd0) begin
            m_cnt = 1; m_rep = 0;
            if (m_cnt >= DEBOUNCE_CNT) begin m_col = (m_col + 1) % 4; m_phase = P_SCAN; end
            else m_phase = P_REL;
          end else begin
`ifdef KEY_REPEAT_EN
            m_rep++;
            if (m_rep >= REPEAT_DELAY && (m_rep - REPEAT_DELAY) % REPEAT_RATE == 0) emit = 1'b1;
`endif
          end
        end
        default: begin
          if (smp == 4'd0) begin
            m_cnt++;
            if (m_cnt == DEBOUNCE_CNT) begin m_col = (m_col + 1) % 4; m_phase = P_SCAN; end
          end else begin
            m_phase = P_HELD; m_rep = 0;
          end
        end
      endcase
    end else begin
      m_dwell++;
    end
    if (emit) begin
      if (!m_valid || hs) begin m_kc = m_code; m_valid = 1'b1; end
      else m_ovr = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0;
    end
    m_h1 = m_h0;
    m_h0 = r;
  endtask

  task automatic check_outputs();
    logic [3:0] exp_col;
    if (!m_known) return;
    exp_col = 4'b0001 << m_col;
    vectors++;
    if (col !== exp_col || key_valid !== m_valid || overrun !== m_ovr || key_code !== m_kc) begin
      miscompares++;
      $display("FAIL cycle_compare t=%0t cyc=%0d: col=%b key_code=%0d key_valid=%b overrun=%b, expected col=%b key_code=%0d key_valid=%b overrun=%b",
               $time, cyc, col, key_code, key_valid, overrun, exp_col, m_kc, m_valid, m_ovr);
    end
  endtask

  task automatic expect_lit(input string name, input int actual, input int required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  // Observe the cycle at the falling edge, then apply the inputs for the next rising edge.
  task automatic step();
    @(negedge clk);
    cyc = prev_reset ? 0 : cyc + 1;
    check_outputs();
    reset     = nx_reset;
    key_ready = nx_ready;
    row       = matrix(pressed, col);
    model_step(row, nx_ready, nx_reset);
    prev_reset = nx_reset;
  endtask

  task automatic restart(input logic [15:0] keys, input bit rdy);
    pressed  = keys;
    nx_ready = rdy;
    nx_reset = 1'b1;
    repeat (3) step();
    nx_reset = 1'b0;
  endtask

  initial begin
    int rise, highs, rise_code, col_a, col_b, col_c, valids, hold, prev_v;
    int rises[$];
    int exp_rise[$];
    logic [15:0] k1, k2;

    // key 9 (row 2, col 1) held, consumer always ready
    restart(16'h1 << 9, 1'b1);
    rise = -1; highs = 0; rise_code = 0; col_a = 0; col_b = 0;
    do begin
      step();
      if (key_valid === 1'b1) begin
        highs++;
        if (rise < 0) begin rise = cyc; rise_code = int'(key_code); end
      end
      if (cyc == 30) begin col_a = int'(col); pressed = '0; end
      if (cyc == 43) col_b = int'(col);
    end while (cyc < 44);
    col_c = int'(col);
    expect_lit("press_latency_cycle", rise, 16);
    expect_lit("press_key_code", rise_code, 9);
    expect_lit("press_valid_cycles", highs, 1);
    expect_lit("held_col_frozen", col_a, 2);
    expect_lit("release_col_still", col_b, 2);
    expect_lit("release_col_advance", col_c, 4);

    // key 3 bounces at successive col 3 samples
    restart('0, 1'b1);
    valids = 0; col_a = 0;
    do begin
      step();
      if (key_valid === 1'b1) valids++;
      if (cyc == 20) col_a = int'(col);
      pressed = (((cyc + 1) >= 12 && (cyc + 1) <= 14) || ((cyc + 1) >= 19 && (cyc + 1) <= 22)) ? 16'h0008 : 16'h0000;
    end while (cyc < 40);
    expect_lit("bounce_no_emit", valids, 0);
    expect_lit("bounce_resume_col0", col_a, 1);

    // rows 0 and 1 together on col 2
    restart((16'h1 << 2) | (16'h1 << 6), 1'b1);
    valids = 0;
    do begin
      step();
      if (key_valid === 1'b1) valids++;
      if (cyc == 4)  expect_lit("ghost_col_c4", int'(col), 2);
      if (cyc == 8)  expect_lit("ghost_col_c8", int'(col), 4);
      if (cyc == 12) expect_lit("ghost_col_c12", int'(col), 8);
      if (cyc == 16) expect_lit("ghost_col_c16", int'(col), 1);
    end while (cyc < 40);
    expect_lit("ghost_no_emit", valids, 0);

    // consumer stalled: key 5, release, key 6 -> overrun, key 5 kept
    restart(16'h1 << 5, 1'b0);
    do begin
      step();
      if (cyc == 50) begin
        expect_lit("overrun_code_kept", int'(key_code), 5);
        expect_lit("overrun_valid", int'(key_valid), 1);
        expect_lit("overrun_flag", int'(overrun), 1);
        pressed = '0;
        nx_ready = 1'b1;
      end
      if (cyc == 51) expect_lit("consume_code", int'(key_code), 5);
      if (cyc == 19) pressed = '0;
      if (cyc == 31) pressed = 16'h1 << 6;
    end while (cyc < 52);
    expect_lit("consume_valid_clear", int'(key_valid), 0);

    // reset while key 3 is being debounced (overrun still set from above)
    pressed = 16'h1 << 3;
    for (int i = 0; i < 200 && m_phase != P_DEB; i++) step();
    expect_lit("reach_debounce", m_phase, P_DEB);
    pressed = '0;
    nx_reset = 1'b1;
    step();
    nx_reset = 1'b0;
    step();
    expect_lit("reset_col", int'(col), 1);
    expect_lit("reset_valid", int'(key_valid), 0);
    expect_lit("reset_overrun", int'(overrun), 0);
    valids = 0;
    repeat (40) begin
      step();
      if (key_valid === 1'b1) valids++;
    end
    expect_lit("reset_no_emit", valids, 0);

    // key 12 held for 20 sample points after acceptance
    restart(16'h1 << 12, 1'b1);
    prev_v = 0;
    do begin
      step();
      if (key_valid === 1'b1 && prev_v == 0) rises.push_back(cyc);
      prev_v = (key_valid === 1'b1) ? 1 : 0;
      if (cyc == 91) pressed = '0;
    end while (cyc < 130);
`ifdef KEY_REPEAT_EN
    exp_rise = '{12, 44, 60, 76, 92};
`else
    exp_rise = '{12};
`endif
    expect_lit("repeat_emit_count", rises.size(), exp_rise.size());
    foreach (exp_rise[i]) expect_lit("repeat_emit_cycle", (i < rises.size()) ? rises[i] : -1, exp_rise[i]);

    // randomized key activity, stalls and occasional resets
    restart('0, 1'b1);
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 60);
        k1 = 16'h1 << $urandom_range(0, 15);
        k2 = 16'h1 << $urandom_range(0, 15);
        case ($urandom_range(0, 9))
          0, 1, 2, 3:    pressed = '0;
          4, 5, 6, 7, 8: pressed = k1;
          default:       pressed = k1 | k2;
        endcase
      end
      hold--;
      nx_ready = ($urandom_range(0, 9) < 6);
      nx_reset = ($urandom_range(0, 599) == 0);
      step();
    end
    nx_reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
